// File: rtl/control_unit.sv
// Multicycle datapath control FSM: fetch, decode, then per-class execute/memory/write-back.
// Every datapath control is a Moore output; the current and next state are exported for debug.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        PCSource1,
    output logic        PCSource0,
    output logic        ALUOp1,
    output logic        ALUOp0,
    output logic        ALUSrcB1,
    output logic        ALUSrcB0,
    output logic        ALUSrcBA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        curS3,
    output logic        curS2,
    output logic        curS1,
    output logic        curS0,
    output logic        curN3,
    output logic        curN2,
    output logic        curN1,
    output logic        curN0
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ctrl;
    logic [5:0]  opcode;
    logic        unused_instr_bits;

    assign opcode            = instruction[5:0];
    assign unused_instr_bits = ^instruction[31:6];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // The opcode only steers Decode and MemAddr; every other state ignores it.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADDR;
                else if (opcode == OP_RTYPE)            state_d = S_EXEC;
                else if (opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (opcode == OP_J)                state_d = S_JUMP;
                else                                    state_d = S_FETCH;
            end
            S_MEMADDR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Bit order: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
    // PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0], ALUSrcBA, RegWrite, RegDst.
    always_comb begin
        ctrl = 16'b0;
        case (state_q)
            S_FETCH:   ctrl = 16'b1001010000001000;
            S_DECODE:  ctrl = 16'b0000000000011000;
            S_MEMADDR: ctrl = 16'b0000000000010100;
            S_MEMRD:   ctrl = 16'b0011000000000000;
            S_MEMWB:   ctrl = 16'b0000001000000010;
            S_MEMWR:   ctrl = 16'b0010100000000000;
            S_EXEC:    ctrl = 16'b0000000001000100;
            S_RWB:     ctrl = 16'b0000000000000011;
            S_BRANCH:  ctrl = 16'b0100000010100100;
            S_JUMP:    ctrl = 16'b1000000100000000;
            default:   ctrl = 16'b0;
        endcase
    end

    assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0,
            ALUSrcBA, RegWrite, RegDst} = ctrl;

    assign {curS3, curS2, curS1, curS0} = state_q;
    assign {curN3, curN2, curN1, curN0} = state_d;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-opcode state walks from a table, plus
// hand sequences for mid-instruction reset and opcode changes between states.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0;
    logic ALUSrcBA, RegWrite, RegDst;
    logic curS3, curS2, curS1, curS0, curN3, curN2, curN1, curN0;

    control_unit dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .PCSource1(PCSource1), .PCSource0(PCSource0),
        .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .ALUSrcB1(ALUSrcB1), .ALUSrcB0(ALUSrcB0),
        .ALUSrcBA(ALUSrcBA), .RegWrite(RegWrite), .RegDst(RegDst),
        .curS3(curS3), .curS2(curS2), .curS1(curS1), .curS0(curS0),
        .curN3(curN3), .curN2(curN2), .curN1(curN1), .curN0(curN0)
    );

    always #5 clock = ~clock;

    logic [15:0] ctrl;
    logic [3:0]  cur_s;
    logic [3:0]  cur_n;
    assign ctrl  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0,
                    ALUSrcBA, RegWrite, RegDst};
    assign cur_s = {curS3, curS2, curS1, curS0};
    assign cur_n = {curN3, curN2, curN1, curN0};

    logic [15:0] out_tab [0:9];

    // seq holds the expected state walk, state k in nibble k, ending back in Fetch.
    typedef struct {
        logic [25:0] upper;
        logic [5:0]  op;
        int          len;
        logic [23:0] seq;
    } vec_t;

    vec_t vecs [0:7];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        check("reset_curS", {12'b0, cur_s}, 16'h0000);
        check("reset_outputs", ctrl, out_tab[0]);
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 32'b0;

        out_tab[0] = 16'b1001010000001000;
        out_tab[1] = 16'b0000000000011000;
        out_tab[2] = 16'b0000000000010100;
        out_tab[3] = 16'b0011000000000000;
        out_tab[4] = 16'b0000001000000010;
        out_tab[5] = 16'b0010100000000000;
        out_tab[6] = 16'b0000000001000100;
        out_tab[7] = 16'b0000000000000011;
        out_tab[8] = 16'b0100000010100100;
        out_tab[9] = 16'b1000000100000000;

        vecs[0] = '{26'h0,       6'b000000, 5, 24'h007610};
        vecs[1] = '{26'h0,       6'b100011, 6, 24'h043210};
        vecs[2] = '{26'h0,       6'b101011, 5, 24'h005210};
        vecs[3] = '{26'h0,       6'b000100, 4, 24'h000810};
        vecs[4] = '{26'h0,       6'b000010, 4, 24'h000910};
        vecs[5] = '{26'h0,       6'b110001, 3, 24'h000010};
        vecs[6] = '{26'h3FFFFFF, 6'b100011, 6, 24'h043210};
        vecs[7] = '{26'h2AAAAAA, 6'b111111, 3, 24'h000010};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            instruction = {vecs[v].upper, vecs[v].op};
            reset = 1'b0;
            for (int k = 0; k < vecs[v].len; k++) begin
                logic [3:0] es;
                logic [3:0] en;
                es = vecs[v].seq[k*4 +: 4];
                check($sformatf("v%0d_s%0d_curS", v, k), {12'b0, cur_s}, {12'b0, es});
                check($sformatf("v%0d_s%0d_out", v, k), ctrl, out_tab[es]);
                if (k < vecs[v].len - 1) begin
                    en = vecs[v].seq[(k+1)*4 +: 4];
                    check($sformatf("v%0d_s%0d_curN", v, k), {12'b0, cur_n}, {12'b0, en});
                end
                @(negedge clock);
            end
        end

        // LW walked to MemRd; an opcode change there must not matter, then reset aborts asynchronously.
        do_reset();
        instruction = 32'h0000_0023;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("lw_in_memrd", {12'b0, cur_s}, 16'h0003);
        instruction = 32'h0000_0002;
        #1;
        check("memrd_ignores_op", {12'b0, cur_n}, 16'h0004);
        #1 reset = 1'b1;
        #1;
        check("async_reset_curS", {12'b0, cur_s}, 16'h0000);
        check("async_reset_out", ctrl, out_tab[0]);
        check("async_reset_curN", {12'b0, cur_n}, 16'h0001);

        // Opcode swapped LW -> SW while in MemAddr steers to MemWr.
        do_reset();
        instruction = 32'h0000_0023;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("memaddr_reached", {12'b0, cur_s}, 16'h0002);
        instruction = 32'h0000_002B;
        #1;
        check("memaddr_sw_curN", {12'b0, cur_n}, 16'h0005);
        @(negedge clock);
        check("memaddr_sw_curS", {12'b0, cur_s}, 16'h0005);
        check("memwr_out", ctrl, out_tab[5]);

        // A non-memory opcode in MemAddr drops back to Fetch.
        do_reset();
        instruction = 32'h0000_002B;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        instruction = 32'h0000_0000;
        #1;
        check("memaddr_other_curN", {12'b0, cur_n}, 16'h0000);
        @(negedge clock);
        check("memaddr_other_curS", {12'b0, cur_s}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
